serial_adder: RTL
=================

Name: serial_adder

Overview:
- Bit-serial adder stage that consumes half-adder cells.
- Processes two WIDTH-bit operands LSB-first, one bit per clock.
- Per-bit datapath: two half adders plus an OR form a full adder; a carry flip-flop closes the loop between bits.
- Operands enter and results leave on valid/ready handshakes. Sits downstream of the combinational half-adder cell in the arithmetic training-circuit set.

Parameters:
- WIDTH, 8, operand and sum width in bits; legal range 2..32.

Ports:
- clk        input   1      rising-edge clock
- rst_n      input   1      asynchronous active-low reset
- in_valid   input   1      operand pair presented
- in_ready   output  1      block can accept operands
- a          input   WIDTH  operand A
- b          input   WIDTH  operand B
- cin        input   1      carry-in
- out_valid  output  1      result available
- out_ready  input   1      downstream accepts result
- sum        output  WIDTH  (a + b + cin) mod 2^WIDTH
- cout       output  1      carry-out of bit WIDTH-1
- busy       output  1      high in RUN or DONE
- ovf        output  1      signed overflow; present only with SERIAL_ADD_OVF_EN

Behaviour:
- Clock and reset: one clock, clk. Reset is rst_n, asynchronous and active-low.
- While rst_n=0:
  - state=IDLE; sum=0, cout=0, out_valid=0, busy=0, ovf=0.
  - Internal shift registers, carry flop and bit counter are cleared.
  - in_ready follows state (1), but all inputs are ignored.
- FSM states: IDLE, RUN, DONE.
- in_ready = (state==IDLE). Combinational, no other term.
- IDLE:
  - Accept when in_valid && in_ready at a rising edge.
  - Load a and b into shift registers, carry flop <= cin, counter <= 0.
  - Next state RUN.
- RUN, each cycle:
  - s = a_sh[0]^b_sh[0]^c
  - c_next = (a_sh[0]&b_sh[0]) | ((a_sh[0]^b_sh[0])&c)
  - a_sh and b_sh shift right by one; s enters the MSB of the sum shift register, which shifts right; carry flop <= c_next; counter increments.
  - When counter==WIDTH-1: cout <= c_next, next state DONE.
- DONE:
  - out_valid=1; sum and cout are held stable.
  - On out_valid && out_ready, next state IDLE and out_valid drops the following cycle.
- Latency:
  - Operand accepted at edge k, out_valid high after edge k+WIDTH.
  - Minimum issue interval is WIDTH+2 cycles (accept, WIDTH RUN cycles, DONE handshake).
- No overlap: a new operand cannot be accepted in the DONE handshake cycle. It is accepted no earlier than the following cycle.
- Operand inputs are sampled only at accept. Changes on a, b or cin during RUN/DONE have no effect.
- in_valid during RUN/DONE is ignored: no buffering, no error.
- out_ready is ignored outside DONE.
- out_ready held low keeps DONE indefinitely; outputs remain stable.
- sum is meaningful only while out_valid=1. After the handshake, sum keeps its last value until the next completion overwrites it. Intermediate shifting is not visible on sum: a separate sum output register loads at the DONE transition.
- Reset mid-operation (RUN or DONE): immediate abort. out_valid=0, no result is ever produced for the aborted operand, and state=IDLE after release.
- Arithmetic:
  - Unsigned modulo 2^WIDTH.
  - {cout,sum} == a+b+cin exactly, as a WIDTH+1-bit result.
- busy = (state!=IDLE).

Optional Feature:
- Macro name: SERIAL_ADD_OVF_EN.
- Defined:
  - ovf port exists.
  - On the final RUN cycle the incoming carry c, which is the carry into the MSB, is captured. ovf <= c ^ c_next, registered alongside cout.
  - ovf is valid with out_valid and stable through DONE; reset value 0.
- Undefined:
  - ovf port and its capture logic are absent.
  - All other behaviour is identical.

Test Plan:
- WIDTH=8. Release reset, send a=0x00 b=0x00 cin=0 -> out_valid exactly 8 cycles after accept, sum=0x00, cout=0, in_ready=0 while busy.
- a=0xFF b=0x01 cin=0 -> sum=0x00, cout=1, ovf=0 (macro on).
- a=0x7F b=0x01 cin=0 -> sum=0x80, cout=0, ovf=1. Then a=0x80 b=0x80 cin=0 -> sum=0x00, cout=1, ovf=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while toggling in_valid with new operands -> out_valid stays 1, sum/cout unchanged, in_ready=0, no second accept. out_ready=1 -> back to IDLE, in_ready=1 next cycle.
- Drop rst_n on the 3rd RUN cycle of a=0xAA b=0x55 -> out_valid never asserts for it, in_ready=1 after release. Next a=0x12 b=0x34 cin=1 -> sum=0x47, cout=0.
- WIDTH=2 exhaustive: all 32 combinations of a, b, cin, back-to-back with out_ready=1 -> every {cout,sum}==a+b+cin. Each result takes 4 cycles from accept to handshake.

Source files
------------

// File: rtl/serial_adder.sv
// serial_adder: bit-serial adder, LSB first, one bit per clock.
// Each bit is added by a full adder built from two half_adder cells and an OR;
// a carry flop links successive bits. Operands and results use valid/ready.
// Optional signed-overflow output is enabled by defining SERIAL_ADD_OVF_EN.

module half_adder (
   input  logic a,
   input  logic b,
   output logic sum,
   output logic carry
);

   assign sum   = a ^ b;
   assign carry = a & b;

endmodule

module serial_adder #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             busy
`ifdef SERIAL_ADD_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int unsigned CW = $clog2(WIDTH);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state;
   state_t           state_next;

   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   // Holds the WIDTH-1 result bits produced so far; the final bit is
   // appended directly when the result register loads.
   logic [WIDTH-2:0] s_sh;
   logic             c;
   logic [CW-1:0]    cnt;

   logic             accept;
   logic             last;
   logic             p;
   logic             g;
   logic             s;
   logic             t;
   logic             c_next;
   logic [WIDTH-1:0] sum_next;

   // Per-bit full adder: two half adders plus an OR.
   half_adder u_ha0 (
      .a     (a_sh[0]),
      .b     (b_sh[0]),
      .sum   (p),
      .carry (g)
   );

   half_adder u_ha1 (
      .a     (p),
      .b     (c),
      .sum   (s),
      .carry (t)
   );

   assign c_next   = g | t;
   assign sum_next = {s, s_sh};
   assign accept   = in_valid && in_ready;
   assign last     = (state == RUN) && (cnt == CW'(WIDTH - 1));

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic.
   always_comb begin
      state_next = state;
      unique case (state)
         IDLE: if (in_valid)  state_next = RUN;
         RUN:  if (last)      state_next = DONE;
         DONE: if (out_ready) state_next = IDLE;
         default:             state_next = IDLE;
      endcase
   end

   // Handshake and status outputs decoded from state.
   always_comb begin
      in_ready  = (state == IDLE);
      out_valid = (state == DONE);
      busy      = (state != IDLE);
   end

   // Operand shift registers, carry flop and bit counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sh <= '0;
         b_sh <= '0;
         s_sh <= '0;
         c    <= 1'b0;
         cnt  <= '0;
      end else if (accept) begin
         a_sh <= a;
         b_sh <= b;
         c    <= cin;
         cnt  <= '0;
      end else if (state == RUN) begin
         a_sh <= {1'b0, a_sh[WIDTH-1:1]};
         b_sh <= {1'b0, b_sh[WIDTH-1:1]};
         s_sh <= sum_next[WIDTH-1:1];
         c    <= c_next;
         cnt  <= cnt + CW'(1);
      end
   end

   // Result registers load only on the final RUN cycle, so shifting is never visible.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum  <= '0;
         cout <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
         ovf  <= 1'b0;
`endif
      end else if (last) begin
         sum  <= sum_next;
         cout <= c_next;
`ifdef SERIAL_ADD_OVF_EN
         // c is the carry into the MSB on this cycle.
         ovf  <= c ^ c_next;
`endif
      end
   end

endmodule
